mem_access_unit: RTL and testbench

//  MEM-stage data-memory responder. Consumes the word address/byte-select/bad-addr triple

---
 rtl/mem_access_unit_pkg.sv | 61 ++++++
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit_lane_align.sv | 63 ++++++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
// Holds the memory opcode encodings, FSM state type and small decode helpers
// used by mem_access_unit and mem_lane_align.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR) || (op == OP_LL);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) || (op == OP_SW) ||
           (op == OP_SWR) || (op == OP_SC);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Left-partial offset: 1111/0111/0011/0001 -> 0..3
  function automatic logic [1:0] left_k(input logic [3:0] sel);
    case (sel)
      4'b0111: return 2'd1;
      4'b0011: return 2'd2;
      4'b0001: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Right-partial offset: 1000/1100/1110/1111 -> 0..3
  function automatic logic [1:0] right_k(input logic [3:0] sel);
    case (sel)
      4'b1100: return 2'd1;
      4'b1110: return 2'd2;
      4'b1111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the memory (slave).
//   req   : request, held until ack or abort
//   we    : write strobe
//   addr  : word address
//   sel   : byte-lane select (big-endian, sel[3] = bits[31:24])
//   wdata : lane-aligned store data
//   ack   : transaction complete this cycle
//   rdata : read data, valid with ack
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational lane steering for the memory stage.
//   st_op/st_sel/st_rt         -> st_wdata  : store data shifted onto bus lanes
//   ld_op/ld_sel/ld_rt/ld_rdata -> ld_result : load extract/extend, LWL/LWR merge
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  st_op,
  input  logic [3:0]  st_sel,
  input  logic [31:0] st_rt,
  input  logic [5:0]  ld_op,
  input  logic [3:0]  ld_sel,
  input  logic [31:0] ld_rt,
  input  logic [31:0] ld_rdata,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_result
);

  logic [1:0]  st_kl, st_kr, ld_kl, ld_kr;
  logic [4:0]  st_shl, st_shr, ld_shl, ld_shr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_kl = left_k(st_sel);
    st_kr = right_k(st_sel);
    ld_kl = left_k(ld_sel);
    ld_kr = right_k(ld_sel);
    // Right-partial shifts by 8*(3-k); 3-k is the bitwise complement of a 2-bit k.
    st_shl = {st_kl, 3'b000};
    st_shr = {~st_kr, 3'b000};
    ld_shl = {ld_kl, 3'b000};
    ld_shr = {~ld_kr, 3'b000};

    case (ld_sel)
      4'b1000: ld_byte = ld_rdata[31:24];
      4'b0100: ld_byte = ld_rdata[23:16];
      4'b0010: ld_byte = ld_rdata[15:8];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_sel[3] ? ld_rdata[31:16] : ld_rdata[15:0];

    case (st_op)
      OP_SB:        st_wdata = {4{st_rt[7:0]}};
      OP_SH:        st_wdata = {2{st_rt[15:0]}};
      OP_SW, OP_SC: st_wdata = st_rt;
      OP_SWL:       st_wdata = st_rt >> st_shl;
      OP_SWR:       st_wdata = st_rt << st_shr;
      default:      st_wdata = '0;
    endcase

    case (ld_op)
      OP_LB:        ld_result = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:       ld_result = {24'h0, ld_byte};
      OP_LH:        ld_result = {{16{ld_half[15]}}, ld_half};
      OP_LHU:       ld_result = {16'h0, ld_half};
      OP_LW, OP_LL: ld_result = ld_rdata;
      OP_LWL:       ld_result = (ld_rdata << ld_shl) | (ld_rt & ~(32'hFFFF_FFFF << ld_shl));
      OP_LWR:       ld_result = (ld_rdata >> ld_shr) | (ld_rt & ~(32'hFFFF_FFFF >> ld_shr));
      default:      ld_result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory responder.
// Accepts one memory instruction in S_IDLE, runs a single req/ack bus
// transaction, then reports the load value / SC status with a 1-cycle o_done.
// Tracks the LL/SC link and aborts a stalled bus cycle after TIMEOUT_CYCLES.
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_req .. i_link_clear  : instruction from ID plus flush/link-clear controls
//   o_busy .. o_bus_err    : pipeline stall, completion and status
//   bus (master)           : data-memory bus
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req,
  input  logic [5:0]               i_instr_op,
  input  logic [31:0]              i_mem_addr,
  input  logic [3:0]               i_mem_sel,
  input  logic                     i_bad_addr,
  input  logic [31:0]              i_rt_value,
  input  logic                     i_flush,
  input  logic                     i_link_clear,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [31:0]              o_result,
  output logic                     o_wb_en,
  output logic                     o_addr_exc,
  output logic                     o_bus_err,
  mem_access_unit_if.master        bus
);

  state_t            state;
  logic [5:0]        op_q;
  logic [31:0]       addr_q, rt_q, wdata_q, result_q, link_addr_q;
  logic [3:0]        sel_q;
  logic              req_q, we_q, busy_q, done_q, wb_en_q, addr_exc_q, bus_err_q;
  logic              link_q, flushed_q;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic              timeout_hit, kill, sc_fail;
  logic [31:0]       st_wdata, ld_result;

  mem_lane_align u_align (
    .st_op     (i_instr_op),
    .st_sel    (i_mem_sel),
    .st_rt     (i_rt_value),
    .ld_op     (op_q),
    .ld_sel    (sel_q),
    .ld_rt     (rt_q),
    .ld_rdata  (bus.rdata),
    .st_wdata  (st_wdata),
    .ld_result (ld_result)
  );

  assign cnt_next    = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next == CNT_W'(TIMEOUT_CYCLES));
  // A flush seen on any wait cycle, including the ack cycle, squashes write-back.
  assign kill        = flushed_q | i_flush;
  assign sc_fail     = (i_instr_op == OP_SC) && (!link_q || (link_addr_q != i_mem_addr));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      sel_q       <= '0;
      rt_q        <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
      link_addr_q <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      addr_exc_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      link_q      <= 1'b0;
      flushed_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      addr_exc_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req && is_mem_op(i_instr_op)) begin
            op_q      <= i_instr_op;
            addr_q    <= i_mem_addr;
            sel_q     <= i_mem_sel;
            rt_q      <= i_rt_value;
            wdata_q   <= st_wdata;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
            result_q  <= '0;
            if (i_bad_addr) begin
              state      <= S_RESP;
              done_q     <= 1'b1;
              addr_exc_q <= 1'b1;
            end else if (sc_fail) begin
              state   <= S_RESP;
              done_q  <= 1'b1;
              wb_en_q <= 1'b1;
            end else begin
              state <= S_WAIT;
              req_q <= 1'b1;
              we_q  <= is_store(i_instr_op);
            end
          end
        end
        S_WAIT: begin
          if (i_flush) flushed_q <= 1'b1;
          if (bus.ack) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            state    <= S_RESP;
            done_q   <= 1'b1;
            result_q <= (op_q == OP_SC) ? 32'd1 : ld_result;
            wb_en_q  <= !kill && (is_load(op_q) || (op_q == OP_SC));
            if (!kill) begin
              if (op_q == OP_LL) begin
                link_q      <= 1'b1;
                link_addr_q <= addr_q;
              end else if (op_q == OP_SC) begin
                link_q <= 1'b0;
              end
            end
          end else if (timeout_hit) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            state     <= S_RESP;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_next;
          end
        end
        S_RESP: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      // Placed last so it overrides an LL completion in the same cycle.
      if (i_link_clear) link_q <= 1'b0;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  // Write-enable is only ever set in S_RESP; a flush there squashes it directly.
  assign o_wb_en    = wb_en_q & ~i_flush;
  assign o_addr_exc = addr_exc_q;
  assign o_bus_err  = bus_err_q;

  assign bus.req    = req_q;
  assign bus.we     = we_q;
  assign bus.addr   = addr_q;
  assign bus.sel    = sel_q;
  assign bus.wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_req;
  logic [5:0]  i_instr_op;
  logic [31:0] i_mem_addr;
  logic [3:0]  i_mem_sel;
  logic        i_bad_addr;
  logic [31:0] i_rt_value;
  logic        i_flush;
  logic        i_link_clear;
  logic        o_busy, o_done, o_wb_en, o_addr_exc, o_bus_err;
  logic [31:0] o_result;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_instr_op   (i_instr_op),
    .i_mem_addr   (i_mem_addr),
    .i_mem_sel    (i_mem_sel),
    .i_bad_addr   (i_bad_addr),
    .i_rt_value   (i_rt_value),
    .i_flush      (i_flush),
    .i_link_clear (i_link_clear),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result),
    .o_wb_en      (o_wb_en),
    .o_addr_exc   (o_addr_exc),
    .o_bus_err    (o_bus_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // side: 0 none, 1 flush on first wait cycle, 2 flush during S_RESP, 3 link clear with ack
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        bad;
    logic [31:0] rt;
    logic [31:0] rdata;
    int unsigned delay;
    logic        has_bus;
    logic        we;
    logic [31:0] wdata;
    logic        chk_res;
    logic [31:0] res;
    logic        wb;
    logic        exc;
    int unsigned side;
  } txn_t;

  typedef struct {
    string       name;
    logic        chk_res;
    logic [31:0] res;
    logic        wb;
    logic        exc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  txn_t vec[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input string name, input logic [5:0] op, input logic [31:0] addr,
                              input logic [3:0] sel, input logic bad, input logic [31:0] rt,
                              input logic [31:0] rdata, input int unsigned delay,
                              input logic has_bus, input logic we, input logic [31:0] wdata,
                              input logic chk_res, input logic [31:0] res, input logic wb,
                              input logic exc, input int unsigned side);
    txn_t t;
    t.name = name; t.op = op; t.addr = addr; t.sel = sel; t.bad = bad; t.rt = rt;
    t.rdata = rdata; t.delay = delay; t.has_bus = has_bus; t.we = we; t.wdata = wdata;
    t.chk_res = chk_res; t.res = res; t.wb = wb; t.exc = exc; t.side = side;
    return t;
  endfunction

  // Completion monitor: every o_done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (i_rst_n && o_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got o_done=1 expected no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_res) check({e.name, ".result"}, o_result, e.res);
        check({e.name, ".wb_en"}, 32'(o_wb_en), 32'(e.wb));
        check({e.name, ".addr_exc"}, 32'(o_addr_exc), 32'(e.exc));
        check({e.name, ".bus_err"}, 32'(o_bus_err), 32'(e.err));
      end
    end
  end

  task automatic run(input txn_t t);
    exp_t e;
    e.name = t.name; e.chk_res = t.chk_res; e.res = t.res;
    e.wb = t.wb; e.exc = t.exc; e.err = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_instr_op = t.op; i_mem_addr = t.addr; i_mem_sel = t.sel;
    i_bad_addr = t.bad; i_rt_value = t.rt;
    sb.push_back(e);
    @(negedge clk);
    i_req = 1'b0; i_bad_addr = 1'b0;
    check({t.name, ".busy"}, 32'(o_busy), 32'd1);
    if (t.has_bus) begin
      check({t.name, ".req"}, 32'(bus.req), 32'd1);
      check({t.name, ".we"}, 32'(bus.we), 32'(t.we));
      check({t.name, ".addr"}, bus.addr, t.addr);
      check({t.name, ".sel"}, 32'(bus.sel), 32'(t.sel));
      if (t.we) check({t.name, ".wdata"}, bus.wdata, t.wdata);
      if (t.side == 1) i_flush = 1'b1;
      for (int i = 0; i < int'(t.delay); i++) begin
        @(negedge clk);
        i_flush = 1'b0;
        check({t.name, ".req_hold"}, 32'(bus.req), 32'd1);
      end
      bus.ack = 1'b1;
      bus.rdata = t.rdata;
      if (t.side == 3) i_link_clear = 1'b1;
      if (t.side == 2) begin
        @(posedge clk);
        #1 i_flush = 1'b1;
      end
      @(negedge clk);
      check({t.name, ".done_lat"}, 32'(o_done), 32'd1);
      check({t.name, ".req_drop"}, 32'(bus.req), 32'd0);
      #1;
      bus.ack = 1'b0; bus.rdata = '0; i_flush = 1'b0; i_link_clear = 1'b0;
    end else begin
      check({t.name, ".no_req"}, 32'(bus.req), 32'd0);
      check({t.name, ".done_lat"}, 32'(o_done), 32'd1);
    end
    @(negedge clk);
    check({t.name, ".idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    exp_t e;
    i_rst_n = 1'b0; i_req = 1'b0; i_instr_op = '0; i_mem_addr = '0; i_mem_sel = '0;
    i_bad_addr = 1'b0; i_rt_value = '0; i_flush = 1'b0; i_link_clear = 1'b0;
    bus.ack = 1'b0; bus.rdata = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(o_busy), 32'd0);
    check("rst.done", 32'(o_done), 32'd0);
    check("rst.result", o_result, 32'd0);
    check("rst.req", 32'(bus.req), 32'd0);
    check("rst.we", 32'(bus.we), 32'd0);
    check("rst.addr", bus.addr, 32'd0);
    check("rst.wdata", bus.wdata, 32'd0);
    i_rst_n = 1'b1;

    vec.push_back(mk("lb",    OP_LB,  32'h100, 4'b0001, 0, 32'h0,        32'h11223380, 0, 1, 0, 0, 1, 32'hFFFFFF80, 1, 0, 0));
    vec.push_back(mk("lbu",   OP_LBU, 32'h104, 4'b0100, 0, 32'h0,        32'h11A23380, 1, 1, 0, 0, 1, 32'h000000A2, 1, 0, 0));
    vec.push_back(mk("lh",    OP_LH,  32'h108, 4'b1100, 0, 32'h0,        32'h80011234, 2, 1, 0, 0, 1, 32'hFFFF8001, 1, 0, 0));
    vec.push_back(mk("lhu",   OP_LHU, 32'h10C, 4'b0011, 0, 32'h0,        32'h1234F00D, 0, 1, 0, 0, 1, 32'h0000F00D, 1, 0, 0));
    vec.push_back(mk("lw_d3", OP_LW,  32'h110, 4'b1111, 0, 32'h0,        32'hDEADBEEF, 3, 1, 0, 0, 1, 32'hDEADBEEF, 1, 0, 0));
    vec.push_back(mk("lwl_k1",OP_LWL, 32'h114, 4'b0111, 0, 32'h11223344, 32'hAABBCCDD, 0, 1, 0, 0, 1, 32'hBBCCDD44, 1, 0, 0));
    vec.push_back(mk("lwl_k0",OP_LWL, 32'h114, 4'b1111, 0, 32'h11223344, 32'hAABBCCDD, 0, 1, 0, 0, 1, 32'hAABBCCDD, 1, 0, 0));
    vec.push_back(mk("lwl_k3",OP_LWL, 32'h114, 4'b0001, 0, 32'h11223344, 32'hAABBCCDD, 0, 1, 0, 0, 1, 32'hDD223344, 1, 0, 0));
    vec.push_back(mk("lwr_k0",OP_LWR, 32'h118, 4'b1000, 0, 32'h11223344, 32'hAABBCCDD, 0, 1, 0, 0, 1, 32'h112233AA, 1, 0, 0));
    vec.push_back(mk("lwr_k1",OP_LWR, 32'h118, 4'b1100, 0, 32'h11223344, 32'hAABBCCDD, 0, 1, 0, 0, 1, 32'h1122AABB, 1, 0, 0));
    vec.push_back(mk("lwr_k2",OP_LWR, 32'h118, 4'b1110, 0, 32'h11223344, 32'hAABBCCDD, 0, 1, 0, 0, 1, 32'h11AABBCC, 1, 0, 0));
    vec.push_back(mk("lwr_k3",OP_LWR, 32'h118, 4'b1111, 0, 32'h11223344, 32'hAABBCCDD, 0, 1, 0, 0, 1, 32'hAABBCCDD, 1, 0, 0));
    vec.push_back(mk("sb",    OP_SB,  32'h120, 4'b0100, 0, 32'h123456A5, 32'h0, 0, 1, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0));
    vec.push_back(mk("sh",    OP_SH,  32'h124, 4'b0011, 0, 32'h0000BEEF, 32'h0, 1, 1, 1, 32'hBEEFBEEF, 0, 0, 0, 0, 0));
    vec.push_back(mk("sw",    OP_SW,  32'h128, 4'b1111, 0, 32'hCAFEF00D, 32'h0, 0, 1, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0));
    vec.push_back(mk("swl_k1",OP_SWL, 32'h12C, 4'b0111, 0, 32'h11223344, 32'h0, 0, 1, 1, 32'h00112233, 0, 0, 0, 0, 0));
    vec.push_back(mk("swl_k3",OP_SWL, 32'h12C, 4'b0001, 0, 32'h11223344, 32'h0, 0, 1, 1, 32'h00000011, 0, 0, 0, 0, 0));
    vec.push_back(mk("swr_k0",OP_SWR, 32'h12C, 4'b1000, 0, 32'h11223344, 32'h0, 0, 1, 1, 32'h44000000, 0, 0, 0, 0, 0));
    vec.push_back(mk("swr_k1",OP_SWR, 32'h12C, 4'b1100, 0, 32'h11223344, 32'h0, 0, 1, 1, 32'h33440000, 0, 0, 0, 0, 0));
    vec.push_back(mk("swr_k3",OP_SWR, 32'h12C, 4'b1111, 0, 32'h11223344, 32'h0, 0, 1, 1, 32'h11223344, 0, 0, 0, 0, 0));
    vec.push_back(mk("lw_bad",OP_LW,  32'h130, 4'b1111, 1, 32'h0,        32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vec.push_back(mk("lw_fr", OP_LW,  32'h134, 4'b1111, 0, 32'h0,        32'h01020304, 0, 1, 0, 0, 1, 32'h01020304, 0, 0, 2));

    foreach (vec[i]) run(vec[i]);

    // Non-memory opcode is ignored.
    @(negedge clk);
    i_req = 1'b1; i_instr_op = 6'h00; i_mem_addr = 32'h140; i_mem_sel = 4'b1111;
    @(negedge clk);
    i_req = 1'b0;
    check("nonmem.busy", 32'(o_busy), 32'd0);
    check("nonmem.req", 32'(bus.req), 32'd0);
    @(negedge clk);
    check("nonmem.done", 32'(o_done), 32'd0);

    // LL/SC: success, then repeat SC fails without a bus cycle.
    run(mk("ll200",  OP_LL, 32'h200, 4'b1111, 0, 32'h0,  32'h00000077, 0, 1, 0, 0, 1, 32'h77, 1, 0, 0));
    run(mk("sc200",  OP_SC, 32'h200, 4'b1111, 0, 32'h55, 32'h0, 1, 1, 1, 32'h55, 1, 32'd1, 1, 0, 0));
    run(mk("sc200b", OP_SC, 32'h200, 4'b1111, 0, 32'h55, 32'h0, 0, 0, 0, 0, 1, 32'd0, 1, 0, 0));

    // Link clear between LL and SC.
    run(mk("ll300", OP_LL, 32'h300, 4'b1111, 0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 32'h0, 1, 0, 0));
    @(negedge clk); i_link_clear = 1'b1;
    @(negedge clk); i_link_clear = 1'b0;
    run(mk("sc300", OP_SC, 32'h300, 4'b1111, 0, 32'h9, 32'h0, 0, 0, 0, 0, 1, 32'd0, 1, 0, 0));

    // Link clear in the LL completion cycle wins.
    run(mk("ll300c", OP_LL, 32'h300, 4'b1111, 0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 32'h0, 1, 0, 3));
    run(mk("sc300c", OP_SC, 32'h300, 4'b1111, 0, 32'h9, 32'h0, 0, 0, 0, 0, 1, 32'd0, 1, 0, 0));

    // Address mismatch, then a flushed LL must not move the link.
    run(mk("ll310",  OP_LL, 32'h310, 4'b1111, 0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 32'h0, 1, 0, 0));
    run(mk("sc314",  OP_SC, 32'h314, 4'b1111, 0, 32'h9, 32'h0, 0, 0, 0, 0, 1, 32'd0, 1, 0, 0));
    run(mk("ll400f", OP_LL, 32'h400, 4'b1111, 0, 32'h0, 32'h5, 1, 1, 0, 0, 0, 32'h0, 0, 0, 1));
    run(mk("sc400",  OP_SC, 32'h400, 4'b1111, 0, 32'h9, 32'h0, 0, 0, 0, 0, 1, 32'd0, 1, 0, 0));

    // Timeout: no ack, request held for exactly 4 wait cycles.
    e.name = "tmo"; e.chk_res = 1'b0; e.res = '0; e.wb = 1'b0; e.exc = 1'b0; e.err = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_instr_op = OP_LW; i_mem_addr = 32'h500; i_mem_sel = 4'b1111;
    sb.push_back(e);
    @(negedge clk);
    i_req = 1'b0;
    n = 0;
    while (bus.req && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("tmo.wait_cycles", n, 32'd4);
    check("tmo.done", 32'(o_done), 32'd1);
    @(negedge clk);
    check("tmo.idle", 32'(o_busy), 32'd0);

    // Reset in the middle of a transaction.
    run(mk("ll600", OP_LL, 32'h600, 4'b1111, 0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 32'h0, 1, 0, 0));
    @(negedge clk);
    i_req = 1'b1; i_instr_op = OP_LW; i_mem_addr = 32'h700; i_mem_sel = 4'b1111;
    @(negedge clk);
    i_req = 1'b0;
    check("rstmid.req_before", 32'(bus.req), 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    check("rstmid.req", 32'(bus.req), 32'd0);
    check("rstmid.busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(mk("sc600", OP_SC, 32'h600, 4'b1111, 0, 32'h9, 32'h0, 0, 0, 0, 0, 1, 32'd0, 1, 0, 0));
    run(mk("lw_after", OP_LW, 32'h704, 4'b1111, 0, 32'h0, 32'h600DF00D, 0, 1, 0, 0, 1, 32'h600DF00D, 1, 0, 0));

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
